// File: rtl/serv_alu_digit.sv
// serv_alu_digit
// Digit-serial ALU: processes one W-bit digit of an XLEN-bit operand pair per
// enabled cycle, least-significant digit first. Carries the add/sub carry and
// the running equality across digits, and registers the final compare result
// at the end of each N = XLEN/W digit pass.
//
// Ports:
//   clk        clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_en       digit strobe; all state advances only when high
//   i_start    with i_en: treat the current digit as digit 0
//   i_sub      1 = subtract (op_b inverted, carry-in 1); required for compares
//   i_bool_op  00 xor, 01 pass op_b, 10 or, 11 and
//   i_cmp_eq   1 = equality compare, 0 = less-than
//   i_cmp_sig  1 = signed less-than
//   i_rd_sel   one-hot result select: [0] add/sub, [1] slt, [2] bool
//   i_rs1      rs1 digit
//   i_op_b     op_b digit
//   o_rd       result digit (combinational)
//   o_cmp      compare result of the last completed pass
//   o_last     high when i_en is high on digit N-1
module serv_alu_digit #(
    parameter int W    = 1,
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_start,
    input  logic         i_sub,
    input  logic [1:0]   i_bool_op,
    input  logic         i_cmp_eq,
    input  logic         i_cmp_sig,
    input  logic [2:0]   i_rd_sel,
    input  logic [W-1:0] i_rs1,
    input  logic [W-1:0] i_op_b,
    output logic [W-1:0] o_rd,
    output logic         o_cmp,
    output logic         o_last
);

    localparam int N  = XLEN / W;
    // Keep the counter at least one bit wide so N = 1 still elaborates.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt_q;
    logic          c_q;
    logic          eq_q;
    logic          cmp_q;

    logic [CW-1:0] d;
    logic [CW-1:0] cnt_nxt;
    logic          is_first;
    logic          is_last;
    logic [W-1:0]  b;
    logic          cin;
    logic [W:0]    add_w;
    logic [W-1:0]  sum;
    logic          co;
    logic          deq;
    logic          eqacc;
    logic          lt;
    logic [W-1:0]  bool_digit;
    logic [W-1:0]  slt_digit;

    // i_start overrides the stored count so an aborted pass is simply discarded.
    assign d        = i_start ? '0 : cnt_q;
    assign is_first = (d == '0);
    assign is_last  = (d == CW'(N - 1));
    assign cnt_nxt  = is_last ? '0 : d + CW'(1);

    assign b     = i_op_b ^ {W{i_sub}};
    assign cin   = is_first ? i_sub : c_q;
    assign add_w = {1'b0, i_rs1} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum   = add_w[W-1:0];
    assign co    = add_w[W];

    assign deq   = (i_rs1 == i_op_b);
    assign eqacc = is_first ? deq : (eq_q & deq);

    // Only meaningful on the last digit, where the top bits are the sign bits.
    // Signed: differing signs decide directly, otherwise the difference sign does.
    always_comb begin
        lt = ~co;
        if (i_cmp_sig) begin
            lt = (i_rs1[W-1] != i_op_b[W-1]) ? i_rs1[W-1] : sum[W-1];
        end
    end

    always_comb begin
        bool_digit = '0;
        case (i_bool_op)
            2'b00:   bool_digit = i_rs1 ^ i_op_b;
            2'b01:   bool_digit = i_op_b;
            2'b10:   bool_digit = i_rs1 | i_op_b;
            default: bool_digit = i_rs1 & i_op_b;
        endcase
    end

    // SLT writes the compare result of the previous pass into bit 0 of digit 0.
    always_comb begin
        slt_digit    = '0;
        slt_digit[0] = cmp_q & is_first;
    end

    assign o_rd = ({W{i_rd_sel[0]}} & sum)
                | ({W{i_rd_sel[1]}} & slt_digit)
                | ({W{i_rd_sel[2]}} & bool_digit);

    assign o_cmp  = cmp_q;
    assign o_last = i_en & is_last;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            c_q   <= 1'b0;
            eq_q  <= 1'b1;
            cmp_q <= 1'b0;
        end else if (i_en) begin
            cnt_q <= cnt_nxt;
            c_q   <= co;
            eq_q  <= eqacc;
            if (is_last) begin
                cmp_q <= i_cmp_eq ? eqacc : lt;
            end
        end
    end

endmodule

// File: tb/tb_serv_alu_digit.sv
module tb_serv_alu_digit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, en1, en8, start, sub, cmp_eq, cmp_sig;
    logic [1:0] bool_op;
    logic [2:0] rd_sel;
    logic [3:0] rs1, opb;
    logic [3:0] rd;
    logic       cmp, last;
    logic       rs1_1, opb_1, rd1, cmp1, last1;
    logic [7:0] rs1_8, opb_8, rd8;
    logic       cmp8, last8;

    int   errors = 0;
    int   checks = 0;
    logic exp_cmp = 1'b0;

    serv_alu_digit #(.W(4), .XLEN(32)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_sub(sub),
        .i_bool_op(bool_op), .i_cmp_eq(cmp_eq), .i_cmp_sig(cmp_sig),
        .i_rd_sel(rd_sel), .i_rs1(rs1), .i_op_b(opb),
        .o_rd(rd), .o_cmp(cmp), .o_last(last)
    );

    serv_alu_digit #(.W(1), .XLEN(32)) dut1 (
        .clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_start(start), .i_sub(sub),
        .i_bool_op(bool_op), .i_cmp_eq(cmp_eq), .i_cmp_sig(cmp_sig),
        .i_rd_sel(rd_sel), .i_rs1(rs1_1), .i_op_b(opb_1),
        .o_rd(rd1), .o_cmp(cmp1), .o_last(last1)
    );

    serv_alu_digit #(.W(8), .XLEN(32)) dut8 (
        .clk(clk), .i_rst_n(rst_n), .i_en(en8), .i_start(start), .i_sub(sub),
        .i_bool_op(bool_op), .i_cmp_eq(cmp_eq), .i_cmp_sig(cmp_sig),
        .i_rd_sel(rd_sel), .i_rs1(rs1_8), .i_op_b(opb_8),
        .o_rd(rd8), .o_cmp(cmp8), .o_last(last8)
    );

    // Whole-word reference: the full 32-bit result the pass must stream out.
    function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [31:0] bb,
                                             input logic s, input logic [2:0] sel,
                                             input logic [1:0] bop, input logic prev_cmp);
        logic [31:0] r;
        r = 32'h0;
        if (sel[0]) r = r | (s ? a - bb : a + bb);
        if (sel[1]) r = r | {31'h0, prev_cmp};
        if (sel[2]) begin
            case (bop)
                2'b00:   r = r | (a ^ bb);
                2'b01:   r = r | bb;
                2'b10:   r = r | (a | bb);
                default: r = r | (a & bb);
            endcase
        end
        return r;
    endfunction

    function automatic logic model_cmp(input logic [31:0] a, input logic [31:0] bb,
                                       input logic s, input logic ceq, input logic csg);
        logic [32:0] t;
        if (ceq) return (a == bb);
        if (s) return csg ? ($signed(a) < $signed(bb)) : (a < bb);
        t = {1'b0, a} + {1'b0, bb};
        if (!csg) return ~t[32];
        return (a[31] != bb[31]) ? a[31] : t[31];
    endfunction

    // Drives up to 8 digits on the W=4 instance; digits == 8 is a complete pass.
    task automatic do_pass(input logic [31:0] a, input logic [31:0] bb, input logic s,
                           input logic [2:0] sel, input logic [1:0] bop,
                           input logic ceq, input logic csg, input logic use_start,
                           input int gap_after, input int digits, input string tag);
        logic [31:0] exp_word;
        exp_word = model_rd(a, bb, s, sel, bop, exp_cmp);
        sub = s; rd_sel = sel; bool_op = bop; cmp_eq = ceq; cmp_sig = csg;
        for (int i = 0; i < digits; i++) begin
            en = 1'b1;
            start = use_start && (i == 0);
            rs1 = a[i*4 +: 4];
            opb = bb[i*4 +: 4];
            #3;
            checks++;
            if (rd !== exp_word[i*4 +: 4])
                $display("FAIL %s rd digit %0d: got %h expected %h", tag, i, rd, exp_word[i*4 +: 4]);
            if (rd !== exp_word[i*4 +: 4]) errors++;
            checks++;
            if (last !== (i == 7)) begin
                errors++;
                $display("FAIL %s o_last digit %0d: got %b expected %b", tag, i, last, (i == 7));
            end
            @(posedge clk); #1;
            if (i == gap_after) begin
                en = 1'b0; start = 1'b0;
                repeat (3) begin
                    #3;
                    checks++;
                    if (last !== 1'b0 || cmp !== exp_cmp) begin
                        errors++;
                        $display("FAIL %s stall: last=%b cmp=%b expected last=0 cmp=%b", tag, last, cmp, exp_cmp);
                    end
                    @(posedge clk); #1;
                end
            end
        end
        en = 1'b0; start = 1'b0;
        if (digits == 8) exp_cmp = model_cmp(a, bb, s, ceq, csg);
        checks++;
        if (cmp !== exp_cmp) begin
            errors++;
            $display("FAIL %s o_cmp: got %b expected %b", tag, cmp, exp_cmp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; en1 = 1'b0; en8 = 1'b0; start = 1'b0;
        sub = 1'b0; cmp_eq = 1'b0; cmp_sig = 1'b0; bool_op = 2'b00; rd_sel = 3'b000;
        rs1 = 4'h0; opb = 4'h0; rs1_1 = 1'b0; opb_1 = 1'b0; rs1_8 = 8'h0; opb_8 = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; en = 1'b0;
        exp_cmp = 1'b0;
        #3;
        checks++;
        if (cmp !== 1'b0 || last !== 1'b0 || cmp1 !== 1'b0 || cmp8 !== 1'b0) begin
            errors++;
            $display("FAIL reset: cmp=%b last=%b cmp1=%b cmp8=%b expected all 0", cmp, last, cmp1, cmp8);
        end
        checks++;
        if (rd !== 4'h0) begin
            errors++;
            $display("FAIL reset rd_sel=0: got %h expected 0", rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_carry();
        do_pass(32'h0000000F, 32'h00000001, 1'b0, 3'b001, 2'b00, 1'b0, 1'b0, 1'b1, -1, 8, "add_carry");
    endtask

    task automatic test_unsigned_cmp();
        do_pass(32'd5, 32'd7, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0, 1'b1, -1, 8, "ucmp_sub");
        do_pass(32'd5, 32'd7, 1'b1, 3'b010, 2'b00, 1'b0, 1'b0, 1'b1, -1, 8, "ucmp_slt");
    endtask

    task automatic test_signed();
        do_pass(32'hFFFFFFFF, 32'h1, 1'b1, 3'b001, 2'b00, 1'b0, 1'b1, 1'b1, -1, 8, "signed_lt");
        do_pass(32'hFFFFFFFF, 32'h1, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0, 1'b1, -1, 8, "unsigned_lt");
    endtask

    task automatic test_equality_stall();
        do_pass(32'h12345678, 32'h12345678, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0, 1'b1, -1, 8, "eq_same");
        do_pass(32'h12345678, 32'h92345678, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0, 1'b1, -1, 8, "eq_diff");
        do_pass(32'h12345678, 32'h12345678, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0, 1'b1, 3, 8, "eq_same_gap");
        do_pass(32'h12345678, 32'h92345678, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0, 1'b1, 3, 8, "eq_diff_gap");
    endtask

    task automatic test_bool();
        for (int op = 0; op < 4; op++)
            do_pass(32'hF0F0A5A5, 32'hFF00FFFF, 1'b1, 3'b100, 2'(op), 1'b1, 1'b0, 1'b1, -1, 8, "bool");
    endtask

    task automatic test_abort_reset();
        // Set cmp to 1 so that an aborted pass leaving it alone is visible.
        do_pass(32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0, 1'b1, -1, 8, "pre_abort");
        do_pass(32'h0, 32'h0, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0, 1'b1, -1, 3, "abort_partial");
        do_pass(32'hFFFFFFFF, 32'h1, 1'b0, 3'b001, 2'b00, 1'b0, 1'b0, 1'b1, -1, 8, "abort_add");
        do_pass(32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0, 1'b1, -1, 8, "pre_reset");
        do_pass(32'h0, 32'h0, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0, 1'b1, -1, 5, "reset_partial");
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cmp = 1'b0;
        #3;
        checks++;
        if (cmp !== 1'b0 || last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pass: cmp=%b last=%b expected 0 0", cmp, last);
        end
        @(posedge clk); #1;
        // No i_start: the counter alone must place this pass at digit 0.
        do_pass(32'h0000000F, 32'h00000001, 1'b0, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, -1, 8, "after_reset");
    endtask

    task automatic test_widths();
        logic [31:0] a, bb, exp_word;
        a = 32'h0000000F; bb = 32'h00000001;
        exp_word = model_rd(a, bb, 1'b0, 3'b001, 2'b00, 1'b0);
        sub = 1'b0; rd_sel = 3'b001; bool_op = 2'b00; cmp_eq = 1'b0; cmp_sig = 1'b0;
        for (int i = 0; i < 32; i++) begin
            en1 = 1'b1; start = (i == 0); rs1_1 = a[i]; opb_1 = bb[i];
            #3;
            checks++;
            if (rd1 !== exp_word[i] || last1 !== (i == 31)) begin
                errors++;
                $display("FAIL w1 digit %0d: rd=%b last=%b expected rd=%b last=%b", i, rd1, last1, exp_word[i], (i == 31));
            end
            @(posedge clk); #1;
        end
        en1 = 1'b0; start = 1'b0;
        checks++;
        if (cmp1 !== model_cmp(a, bb, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL w1 o_cmp: got %b expected %b", cmp1, model_cmp(a, bb, 1'b0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 4; i++) begin
            en8 = 1'b1; start = (i == 0); rs1_8 = a[i*8 +: 8]; opb_8 = bb[i*8 +: 8];
            #3;
            checks++;
            if (rd8 !== exp_word[i*8 +: 8] || last8 !== (i == 3)) begin
                errors++;
                $display("FAIL w8 digit %0d: rd=%h last=%b expected rd=%h last=%b", i, rd8, last8, exp_word[i*8 +: 8], (i == 3));
            end
            @(posedge clk); #1;
        end
        en8 = 1'b0; start = 1'b0;
        checks++;
        if (cmp8 !== model_cmp(a, bb, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL w8 o_cmp: got %b expected %b", cmp8, model_cmp(a, bb, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, bb;
        logic [2:0]  sel;
        int          gap;
        for (int k = 0; k < 40; k++) begin
            a  = $urandom;
            bb = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) bb = a ^ 32'h80000000;
            sel = 3'($urandom_range(0, 7));
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            do_pass(a, bb, 1'b1, sel, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gap, 8, "random");
        end
    endtask

    initial begin
        test_reset();
        test_widths();
        test_add_carry();
        test_unsigned_cmp();
        test_signed();
        test_equality_stall();
        test_bool();
        test_abort_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
